kt1_demux_sched: RTL and testbench

Scheduler that shares the KT1 1-to-8 demultiplexer (enable E, data A, select S[2:0]) between 8 requesting channels. Each channel posts a request and a data bit. The block grants one channel at a time and drives E/A/S for a fixed dwell time. It enforces a break-before-make gap between grants and returns a one-cycle acknowledge. It sits directly in front of the KT1 instance; its E, A and S outputs connect straight to the KT1 inputs of the same name.

---
 rtl/kt1_sched_pkg.sv | 25 ++
 rtl/kt1_demux_sched_if.sv | 21 ++
 rtl/kt1_rr_pick.sv | 34 +++
 rtl/kt1_demux_sched.sv | 106 ++++++++++
 tb/tb_kt1_demux_sched.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/kt1_sched_pkg.sv
// kt1_sched_pkg -- shared constants for the KT1 demux scheduler.
//   ST_*        : FSM state encodings (IDLE / DRIVE / GAP)
//   N_CH_DEF    : default channel count (KT1 output width)
//   SEL_W_DEF   : default select width, clog2(N_CH_DEF)
//   cnt_w()     : dwell/gap counter width, clog2(max(DWELL, GAP) + 1)
package kt1_sched_pkg;

    localparam int N_CH_DEF  = 8;
    localparam int SEL_W_DEF = 3;
    localparam int DWELL_DEF = 4;
    localparam int GAP_DEF   = 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    function automatic int cnt_w(input int dwell, input int gap);
        int m;
        m = (dwell > gap) ? dwell : gap;
        return $clog2(m + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_w(DWELL_DEF, GAP_DEF);

endpackage

// File: rtl/kt1_demux_sched_if.sv
// kt1_demux_sched_if -- request side and KT1 drive side of the scheduler.
//   REQ/DIN  : per-channel request level and data bit (requesters -> scheduler)
//   E/A/S    : KT1 enable, data, select (scheduler -> KT1)
//   ACK      : one-hot one-cycle completion pulse
//   BUSY     : scheduler not idle
// Modports: slave = scheduler, master = requesters / observer.
interface kt1_demux_sched_if #(
    parameter int N_CH  = 8,
    parameter int SEL_W = 3
);
    logic [N_CH-1:0]  REQ;
    logic [N_CH-1:0]  DIN;
    logic             E;
    logic             A;
    logic [SEL_W-1:0] S;
    logic [N_CH-1:0]  ACK;
    logic             BUSY;

    modport slave  (input REQ, DIN, output E, A, S, ACK, BUSY);
    modport master (output REQ, DIN, input E, A, S, ACK, BUSY);
endinterface

// File: rtl/kt1_rr_pick.sv
// kt1_rr_pick -- combinational channel picker.
//   req   : request vector
//   ptr   : round-robin start index (ignored in priority mode)
//   ch    : winning channel index
//   valid : any request present
// Build option KT1_SCHED_PRIO_EN: lowest set request index wins.
// Default: first set request at or after ptr, wrapping N_CH-1 -> 0.
module kt1_rr_pick #(
    parameter int N_CH  = 8,
    parameter int SEL_W = 3
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] ch,
    output logic             valid
);
    always_comb begin
        ch    = '0;
        valid = |req;
`ifdef KT1_SCHED_PRIO_EN
        // Scan high to low so the lowest set index is written last.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[i]) ch = SEL_W'(i);
        end
`else
        // Scan offsets high to low so the smallest offset from ptr wins.
        for (int i = N_CH - 1; i >= 0; i--) begin
            int idx;
            idx = (int'(ptr) + i) % N_CH;
            if (req[idx]) ch = SEL_W'(idx);
        end
`endif
    end
endmodule

// File: rtl/kt1_demux_sched.sv
// kt1_demux_sched -- grants one of N_CH requesters at a time onto the KT1
// 1-to-N demux, holding E high for DWELL cycles, then E low for GAP cycles
// before the next arbitration. All outputs registered.
//   CLK  : clock, rising edge
//   RST  : synchronous active-high reset
//   bus  : kt1_demux_sched_if.slave (REQ/DIN in, E/A/S/ACK/BUSY out)
// Build option KT1_SCHED_PRIO_EN: fixed lowest-index priority, the
// round-robin pointer is never updated.
module kt1_demux_sched
    import kt1_sched_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int SEL_W = SEL_W_DEF,
    parameter int DWELL = DWELL_DEF,
    parameter int GAP   = GAP_DEF
) (
    input logic CLK,
    input logic RST,
    kt1_demux_sched_if.slave bus
);
    localparam int CNT_W = cnt_w(DWELL, GAP);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] pick_ch;
    logic             pick_vld;

    logic             e_q, a_q, busy_q;
    logic [SEL_W-1:0] s_q;
    logic [N_CH-1:0]  ack_q;

    kt1_rr_pick #(.N_CH(N_CH), .SEL_W(SEL_W)) u_pick (
        .req   (bus.REQ),
        .ptr   (ptr),
        .ch    (pick_ch),
        .valid (pick_vld)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            ptr    <= '0;
            e_q    <= 1'b0;
            a_q    <= 1'b0;
            s_q    <= '0;
            ack_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            // ACK is a single-cycle pulse; only the DRIVE exit raises it.
            ack_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        s_q    <= pick_ch;
                        a_q    <= bus.DIN[pick_ch];
                        e_q    <= 1'b1;
                        busy_q <= 1'b1;
                        cnt    <= CNT_W'(DWELL - 1);
                        state  <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (cnt == '0) begin
                        e_q   <= 1'b0;
                        ack_q <= N_CH'(1) << s_q;
`ifndef KT1_SCHED_PRIO_EN
                        ptr   <= (s_q == SEL_W'(N_CH - 1)) ? '0 : s_q + SEL_W'(1);
`endif
                        if (GAP > 0) begin
                            cnt   <= CNT_W'((GAP > 0) ? GAP - 1 : 0);
                            state <= ST_GAP;
                        end else begin
                            busy_q <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    // S is left alone here; it only moves on the next grant.
                    if (cnt == '0) begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    e_q    <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.E    = e_q;
    assign bus.A    = a_q;
    assign bus.S    = s_q;
    assign bus.ACK  = ack_q;
    assign bus.BUSY = busy_q;

endmodule

// File: tb/tb_kt1_demux_sched.sv
// tb_kt1_demux_sched -- directed vectors for kt1_demux_sched with
// DWELL=4, GAP=1. Inputs change and outputs are sampled on the falling edge.
module tb_kt1_demux_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    kt1_demux_sched_if #(.N_CH(8), .SEL_W(3)) bus ();

    kt1_demux_sched #(.N_CH(8), .SEL_W(3), .DWELL(4), .GAP(1)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".E"},    32'(bus.E),    32'd0);
        chk({tag, ".ACK"},  32'(bus.ACK),  32'd0);
        chk({tag, ".BUSY"}, 32'(bus.BUSY), 32'd0);
    endtask

    // One full grant: the arbitrating edge has not happened yet on entry.
    // After the first DRIVE sample REQ/DIN are replaced to show they are ignored.
    task automatic grant(input string tag, input int ch, input logic a,
                         input logic [7:0] req_after, input logic [7:0] din_after);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk({tag, ".E"},    32'(bus.E),    32'd1);
            chk({tag, ".S"},    32'(bus.S),    32'(ch));
            chk({tag, ".A"},    32'(bus.A),    32'(a));
            chk({tag, ".ACK"},  32'(bus.ACK),  32'd0);
            chk({tag, ".BUSY"}, 32'(bus.BUSY), 32'd1);
            if (k == 0) begin
                bus.REQ = req_after;
                bus.DIN = din_after;
            end
        end
        tick();
        chk({tag, ".E_fall"}, 32'(bus.E),    32'd0);
        chk({tag, ".ACK"},    32'(bus.ACK),  32'(8'd1 << ch));
        chk({tag, ".BUSYg"},  32'(bus.BUSY), 32'd1);
        chk({tag, ".Sg"},     32'(bus.S),    32'(ch));
        tick();
        chk_idle({tag, ".idle"});
        chk({tag, ".Si"}, 32'(bus.S), 32'(ch));
    endtask

    initial begin
        bus.REQ = 8'hFF;
        bus.DIN = 8'hFF;

        // 1. reset held two cycles with all requests up
        for (int k = 0; k < 2; k++) begin
            tick();
            chk_idle("rst");
            chk("rst.S", 32'(bus.S), 32'd0);
            chk("rst.A", 32'(bus.A), 32'd0);
        end
        bus.REQ = 8'h00;
        rst = 1'b0;
        tick();
        chk_idle("rst_rel");

        // 2. single grant on channel 5; DIN flips mid-grant, A must hold
        bus.REQ = 8'h20;
        bus.DIN = 8'h20;
        grant("single", 5, 1'b1, 8'h00, 8'h00);

        // reset so the round-robin pointer restarts at 0
        rst = 1'b1;
        tick();
        rst = 1'b0;

`ifdef KT1_SCHED_PRIO_EN
        // 6. fixed priority: channel 0 always wins
        bus.REQ = 8'h81;
        bus.DIN = 8'h01;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (bus.E) chk("prio.S", 32'(bus.S), 32'd0);
            chk("prio.ACK", 32'(bus.ACK & 8'hFE), 32'd0);
        end
        bus.REQ = 8'h00;
        for (int k = 0; k < 6; k++) tick();
        chk_idle("prio.end");
`else
        // 3. round robin 0,7,0,7 with both held
        bus.REQ = 8'h81;
        bus.DIN = 8'h01;
        grant("rr0a", 0, 1'b1, 8'h81, 8'h01);
        grant("rr7a", 7, 1'b0, 8'h81, 8'h01);
        grant("rr0b", 0, 1'b1, 8'h81, 8'h01);
        grant("rr7b", 7, 1'b0, 8'h81, 8'h01);
`endif

        // 4. request withdrawn during DRIVE; grant still completes
        bus.REQ = 8'h02;
        bus.DIN = 8'h00;
        grant("wd1", 1, 1'b0, 8'h00, 8'h02);
        tick();
        chk_idle("wd.hold");

        // 5. reset on the second DRIVE cycle of channel 3
        bus.REQ = 8'h08;
        bus.DIN = 8'h08;
        tick();
        chk("rst3.E", 32'(bus.E), 32'd1);
        chk("rst3.S", 32'(bus.S), 32'd3);
        rst = 1'b1;
        bus.REQ = 8'h00;
        tick();
        chk_idle("rst3");
        chk("rst3.S0", 32'(bus.S), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_idle("rst3.noack");
        end
        // pointer back at 0: channel 0 beats channel 7
        bus.REQ = 8'h81;
        bus.DIN = 8'h80;
        grant("ptr0", 0, 1'b0, 8'h00, 8'h00);

`ifndef KT1_SCHED_PRIO_EN
        // three pending after channel 0 served: pointer=1 -> 2, 3, 5
        bus.REQ = 8'h2C;
        bus.DIN = 8'h08;
        grant("multi2", 2, 1'b0, 8'h2C, 8'h08);
        grant("multi3", 3, 1'b1, 8'h2C, 8'h08);
        grant("multi5", 5, 1'b0, 8'h00, 8'h08);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
